// File: rtl/keccak_msg_feeder.sv
// Serializes a byte-length command plus DW-bit data words into 64-bit padder chunks.
// Define KECCAK_FEEDER_BYTESWAP_EN to byte-reverse each chunk driven on `in`.
module keccak_msg_feeder #(
    parameter int IW   = 64,
    parameter int DW   = 512,
    parameter int LENW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [LENW-1:0] cmd_len,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic [DW-1:0]   din,
    output logic [IW-1:0]   in,
    output logic            in_ready,
    output logic            is_last,
    output logic [3:0]      byte_num,
    input  logic            buffer_full,
    output logic            msg_done,
    output logic            busy
);
    localparam int NCH  = DW / IW;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_TAIL, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [LENW-1:0] rem_q, rem_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [DW-1:0]   sh_q, sh_d;

    logic            accept;
    logic            rem_lt8;
    logic            rem_eq8;
    logic            idx_last;
    logic [IW-1:0]   chunk;
    logic [IW-1:0]   chunk_out;

    assign accept   = (state_q == S_SEND || state_q == S_TAIL) && !buffer_full;
    assign rem_lt8  = rem_q < LENW'(8);
    assign rem_eq8  = rem_q == LENW'(8);
    assign idx_last = idx_q == IDXW'(NCH - 1);
    // The current chunk always sits at the bottom of the shift register.
    assign chunk    = sh_q[IW-1:0];

`ifdef KECCAK_FEEDER_BYTESWAP_EN
    always_comb begin
        chunk_out = '0;
        for (int b = 0; b < IW / 8; b++) begin
            chunk_out[IW-1-8*b -: 8] = chunk[8*b +: 8];
        end
    end
`else
    assign chunk_out = chunk;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (cmd_valid) begin
                state_d = (cmd_len == '0) ? S_TAIL : S_LOAD;
            end
            S_LOAD: if (din_valid) state_d = S_SEND;
            S_SEND: if (accept) begin
                if (rem_lt8)       state_d = S_DONE;
                else if (rem_eq8)  state_d = S_TAIL;
                else if (idx_last) state_d = S_LOAD;
            end
            S_TAIL: if (accept) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rem_d = rem_q;
        idx_d = idx_q;
        sh_d  = sh_q;
        if (state_q == S_IDLE && cmd_valid) begin
            rem_d = cmd_len;
        end
        if (state_q == S_LOAD && din_valid) begin
            sh_d  = din;
            idx_d = '0;
        end
        if (state_q == S_SEND && accept && !rem_lt8 && !rem_eq8) begin
            rem_d = rem_q - LENW'(8);
            idx_d = idx_q + 1'b1;
            sh_d  = sh_q >> IW;
        end
    end

    always_comb begin
        cmd_ready = 1'b0;
        din_ready = 1'b0;
        in        = '0;
        in_ready  = 1'b0;
        is_last   = 1'b0;
        byte_num  = 4'd0;
        msg_done  = 1'b0;
        busy      = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: cmd_ready = 1'b1;
            S_LOAD: din_ready = 1'b1;
            S_SEND: begin
                in       = chunk_out;
                in_ready = 1'b1;
                if (rem_lt8) begin
                    is_last  = 1'b1;
                    byte_num = rem_q[3:0];
                end
            end
            S_TAIL: begin
                in_ready = 1'b1;
                is_last  = 1'b1;
            end
            S_DONE: msg_done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Self-checking bench for keccak_msg_feeder: directed plan cases plus random lengths
// and random back-pressure, checked against a chunk-list reference model.
module tb_keccak_msg_feeder;
    localparam int IW   = 64;
    localparam int DW   = 512;
    localparam int LENW = 16;
    localparam int NCH  = DW / IW;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [LENW-1:0] cmd_len;
    logic            din_valid;
    logic            din_ready;
    logic [DW-1:0]   din;
    logic [IW-1:0]   in_w;
    logic            in_ready;
    logic            is_last;
    logic [3:0]      byte_num;
    logic            buffer_full;
    logic            msg_done;
    logic            busy;

    int vecs = 0;
    int errs = 0;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic [3:0]  bn;
        logic [63:0] m;
    } exp_t;

    logic [DW-1:0] dq[$];
    exp_t          eq[$];

    always #5 clk = ~clk;

    keccak_msg_feeder #(.IW(IW), .DW(DW), .LENW(LENW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .in(in_w), .in_ready(in_ready), .is_last(is_last),
        .byte_num(byte_num), .buffer_full(buffer_full),
        .msg_done(msg_done), .busy(busy)
    );

    function automatic logic [63:0] swap(input logic [63:0] c);
`ifdef KECCAK_FEEDER_BYTESWAP_EN
        return {<<8{c}};
`else
        return c;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode: 0 no stall, 1 random stall, 2 five-cycle stall on 2nd chunk,
    // 3 reset during the 3rd chunk
    task automatic run_msg(input int len, input int mode, input bit fix0,
                           input logic [63:0] c0);
        int nd, nw, tl, acc, stl, cons, first, cyc, r;
        bit done, aborted, bf, prev_st, last;
        logic [63:0] prev_in;
        logic [DW-1:0] w;
        exp_t e;
        nd = (len + 7) / 8;
        nw = (nd + NCH - 1) / NCH;
        tl = (len % 8 == 0) ? 1 : 0;
        dq.delete();
        eq.delete();
        for (int i = 0; i <= nw; i++) begin
            for (int j = 0; j < DW / 32; j++) w[32*j +: 32] = $urandom;
            if (i == 0 && fix0) w[63:0] = c0;
            dq.push_back(w);
        end
        for (int i = 0; i < nd; i++) begin
            last = (i == nd - 1) && (tl == 0);
            w = dq[i / NCH];
            e.d  = swap(w[64*(i % NCH) +: 64]);
            e.l  = last;
            e.bn = last ? 4'(len % 8) : 4'd0;
            e.m  = last ? swap((64'd1 << (8 * (len % 8))) - 64'd1) : '1;
            eq.push_back(e);
        end
        if (tl == 1) eq.push_back('{d: 64'd0, l: 1'b1, bn: 4'd0, m: '1});

        @(negedge clk);
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_valid   = 1'b1;
        cmd_len     = LENW'(len);
        din_valid   = 1'b1;
        din         = dq[0];
        buffer_full = 1'b0;
        @(posedge clk);
        acc = 0; stl = 0; cons = 0; first = 0;
        done = 0; aborted = 0; prev_st = 0; prev_in = '0;
        for (cyc = 1; cyc <= 300 && !done; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (msg_done) begin
                chk("done_cycle", 64'(cyc), 64'(nw + nd + tl + stl + 1));
                chk("accepts", 64'(acc), 64'(nd + tl));
                chk("din_used", 64'(cons), 64'(nw));
                done = 1;
            end else if (mode == 3 && acc == 2 && in_ready) begin
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("rst_in_ready", 64'(in_ready), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
                chk("rst_in", in_w, 64'd0);
                reset = 1'b0;
                for (r = 0; r < 4; r++) begin
                    chk("rst_msg_done", 64'(msg_done), 64'd0);
                    @(negedge clk);
                end
                done = 1;
                aborted = 1;
            end else begin
                bf = 0;
                if (mode == 1) bf = ($urandom_range(0, 2) == 0);
                if (mode == 2 && acc == 1 && stl < 5) bf = 1;
                buffer_full = bf;
                din = (dq.size() > 0) ? dq[0] : '0;
                if (din_ready) begin
                    cons++;
                    if (dq.size() > 0) void'(dq.pop_front());
                end
                if (in_ready) begin
                    if (first == 0) begin
                        first = cyc;
                        chk("latency", 64'(cyc), (len == 0) ? 64'd1 : 64'd2);
                    end
                    if (eq.size() == 0) begin
                        chk("extra_chunk", 64'(in_ready), 64'd0);
                    end else begin
                        chk("in", in_w & eq[0].m, eq[0].d & eq[0].m);
                        chk("is_last", 64'(is_last), 64'(eq[0].l));
                        chk("byte_num", 64'(byte_num), 64'(eq[0].bn));
                        if (prev_st) chk("stall_hold", in_w, prev_in);
                        if (bf) stl++;
                        else begin
                            acc++;
                            void'(eq.pop_front());
                        end
                    end
                    prev_st = bf;
                    prev_in = in_w;
                end else begin
                    chk("idle_last", {59'd0, is_last, byte_num}, 64'd0);
                    prev_st = 0;
                end
            end
        end
        buffer_full = 1'b0;
        din_valid   = 1'b0;
        if (!done) chk("timeout", 64'd1, 64'd0);
        else if (!aborted) begin
            @(negedge clk);
            chk("done_pulse", 64'(msg_done), 64'd0);
            chk("back_idle", 64'(cmd_ready), 64'd1);
        end
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_len = '0;
        din_valid = 1'b0;
        din = '0;
        buffer_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_din_ready", 64'(din_ready), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_is_last", 64'(is_last), 64'd0);
        chk("rst_byte_num", 64'(byte_num), 64'd0);
        chk("rst_in", in_w, 64'd0);
        chk("rst_msg_done", 64'(msg_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;

        run_msg(5, 0, 1'b1, 64'h0011223344556677);
        run_msg(16, 0, 1'b0, 64'd0);
        run_msg(70, 0, 1'b0, 64'd0);
        run_msg(0, 0, 1'b0, 64'd0);
        run_msg(24, 2, 1'b0, 64'd0);
        run_msg(40, 3, 1'b0, 64'd0);
        run_msg(5, 0, 1'b0, 64'd0);
        run_msg(64, 1, 1'b0, 64'd0);
        for (int n = 0; n < 12; n++) begin
            run_msg(int'($urandom_range(0, 150)), 1, 1'b0, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/keccak_msg_feeder.md
# keccak_msg_feeder

Upstream message serializer for the Keccak-512 integrity hash. It accepts a byte-length command and a stream of wide data words from the ORAM integrity logic. It slices them into 64-bit chunks and drives the padder's `in`/`in_ready`/`is_last`/`byte_num` inputs. It obeys the padder's `buffer_full` back-pressure and generates the terminating short or empty word the padder needs.

## Interface

Parameters:

- `IW`, 64: chunk width delivered to the padder; fixed at 64.
- `DW`, 512: input data word width; a multiple of `IW`.
- `LENW`, 16: width of the message byte-length field.

Ports:

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: new message command.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_len` in `LENW`: message length in bytes; 0 is legal.
- `din_valid` in 1: data word valid.
- `din_ready` out 1: high only in LOAD.
- `din` in `DW`: data; chunk k = `din[IW*k+IW-1 : IW*k]`, chunk 0 sent first.
- `in` out `IW`: chunk to the padder.
- `in_ready` out 1: `in` is valid.
- `is_last` out 1: final chunk of the message; 0 whenever `in_ready`=0.
- `byte_num` out 4: valid bytes in the final chunk (0..7); 0 when `is_last`=0.
- `buffer_full` in 1: padder back-pressure.
- `msg_done` out 1: one-cycle pulse after the final chunk is accepted.
- `busy` out 1: state ≠ IDLE.

## Operation

- States: IDLE, LOAD, SEND, TAIL, DONE.
- A chunk is accepted in any cycle with `in_ready && !buffer_full`.
- IDLE:
  - `cmd_valid` latches `cmd_len` into `rem` (LENW bits).
  - `cmd_len`=0 → TAIL; otherwise → LOAD.
- LOAD:
  - `din_valid` captures `din` into the shift register and sets the chunk index to 0.
  - Next state is SEND.
- SEND:
  - `in` = current chunk; `in_ready`=1.
  - `is_last`=1 and `byte_num`=`rem[3:0]` only when `rem`<8. Bytes above `byte_num` are don't-care.
  - On accept with `rem`<8 → DONE.
  - On accept with `rem`=8 → TAIL.
  - On accept with `rem`>8: `rem` −= 8 and the index increments. If the index was `DW/IW`−1 → LOAD, otherwise stay in SEND.
- TAIL:
  - Drives `in`=0, `in_ready`=1, `is_last`=1, `byte_num`=0.
  - On accept → DONE.
  - This covers messages whose length is a multiple of 8, including length 0.
- DONE: `msg_done`=1 for one cycle, then → IDLE.
- Unused chunks of the final `din` word are discarded. Surplus `din` words are not consumed.
- The block never re-arms the padder. Resetting the padder between messages is the integrity controller's job.

## Timing

- Reset values:
  - state IDLE; `rem`=0; index 0; shift register 0.
  - `cmd_ready`=1, `din_ready`=0, `in_ready`=0, `is_last`=0, `byte_num`=0, `in`=0, `msg_done`=0, `busy`=0.
- All outputs are decoded from registered state and data. There are no combinational paths from `buffer_full` or the valid inputs to any output.
- Command accept to first `in_ready`:
  - Data path: 2 cycles (IDLE→LOAD→SEND), assuming `din_valid` is already high.
  - `cmd_len`=0: 1 cycle.
- Steady state: 1 chunk per cycle while `buffer_full`=0.
- Each new `DW` word costs one LOAD bubble cycle.
- While `buffer_full`=1, `in`/`is_last`/`byte_num` hold stable and state does not advance.
- `msg_done` rises the cycle after the final accept.
- Reset mid-message: on the next edge return to IDLE, drop all captured data, deassert `in_ready`. No partial `msg_done` is produced.
- `rem` decrement never underflows, because the `rem`≤8 cases exit SEND.

## Configuration

- `KECCAK_FEEDER_BYTESWAP_EN`:
  - Defined: each 64-bit chunk is byte-reversed before driving `in` (byte 0 → `in[63:56]`). This matches the big-endian lane order of the integrity MAC.
  - Undefined: `in` equals the raw chunk.
- The `byte_num` and `is_last` semantics are identical in both builds.

## Test plan

- `cmd_len`=5, `din[63:0]`=64'h0011223344556677, `buffer_full`=0 → exactly one accepted chunk: `is_last`=1, `byte_num`=5, `in`=64'h0011223344556677. Then `msg_done` pulse; exactly 1 `din` consumed.
- `cmd_len`=16 → two chunks with `is_last`=0, then a TAIL word: `in`=0, `is_last`=1, `byte_num`=0. 3 accepts total.
- `cmd_len`=70 at DW=512 → 8 full chunks, a LOAD bubble, second `din` consumed, then chunk 0 with `is_last`=1, `byte_num`=6. 2 `din` words consumed, 9 accepts.
- `cmd_len`=0 → single TAIL word (`byte_num`=0, `is_last`=1). `din_ready` never asserts.
- `cmd_len`=24, `buffer_full`=1 for 5 cycles on the second chunk → `in` stable throughout; `is_last`=0 during the stall. Completes with 4 accepts after release.
- `reset` asserted during the 3rd chunk of `cmd_len`=40 → next cycle IDLE, `in_ready`=0, no `msg_done`. A fresh `cmd_len`=5 then completes normally.
- With `KECCAK_FEEDER_BYTESWAP_EN` defined: chunk 64'h0011223344556677 appears as `in`=64'h7766554433221100.
